// File: rtl/fifo_drain_pkg.sv
// Shared types and defaults for the peripheral-side FIFO drain controller.
package fifo_drain_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned WORDS_W     = 32;
    localparam int unsigned FLUSH_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } drain_state_e;

endpackage

// File: rtl/drain_skid_fifo.sv
// Small synchronous FIFO that absorbs read-latency words ahead of the downstream stream.
module drain_skid_fifo
    import fifo_drain_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] din_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop;

    assign do_pop   = pop_i && (count_q != '0);
    assign wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign count_d  = count_q + CNT_W'(push_i) - CNT_W'(do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the read port is masked while empty instead.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_i && !do_pop) begin
            assert (count_q != CNT_W'(DEPTH)) else $error("skid buffer overflow");
        end
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains the async FIFO read port in credit-limited bursts onto a valid/ready stream.
module fifo_drain_ctrl
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned SKID_D = 4,
    parameter int unsigned BLEN_W = 8
) (
    input  logic               clk_periph,
    input  logic               periph_rst,
    input  logic               enable,
    input  logic [BLEN_W-1:0]  burst_len,
    output logic               rd_en,
    input  logic [DATA_W-1:0]  rd_data,
    input  logic               rd_valid,
    input  logic               rd_empty,
    input  logic               rd_full,
    input  logic               irq_full,
    input  logic               irq_empty,
    output logic               irq_clear_full,
    output logic               irq_clear_empty,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic [WORDS_W-1:0] words_sent
);

    localparam int unsigned CNT_W = $clog2(SKID_D) + 1;

    drain_state_e       state_q, state_d;
    logic [BLEN_W-1:0]  blen_q, blen_d;
    logic [BLEN_W-1:0]  issued_q, issued_d;
    logic [BLEN_W-1:0]  sent_q, sent_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [FLUSH_W-1:0] flush_q, flush_d;
    logic [WORDS_W-1:0] words_sent_q, words_sent_d;

    logic [CNT_W-1:0]   skid_cnt;
    logic               skid_empty;
    logic [CNT_W:0]     credit_sum;
    logic               credit_ok, valid_eff, accept, last_beat;
    logic               rd_en_c, clr_full_c, clr_empty_c;
    logic               unused_rd_full;

    // rd_full is a status level the drain decision does not need.
    assign unused_rd_full = rd_full;

    // Words still in flight from before a reset land in this window and are dropped.
    assign valid_eff  = rd_valid && (flush_q == '0);
    assign accept     = m_valid && m_ready;
    assign last_beat  = (sent_q == blen_q - BLEN_W'(1));
    assign credit_sum = {1'b0, outst_q} + {1'b0, skid_cnt};
    assign credit_ok  = credit_sum < (CNT_W + 1)'(SKID_D);

    drain_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_D)
    ) u_skid (
        .clk_i   (clk_periph),
        .rst_i   (periph_rst),
        .push_i  (valid_eff),
        .din_i   (rd_data),
        .pop_i   (accept),
        .dout_o  (m_data),
        .empty_o (skid_empty),
        .count_o (skid_cnt)
    );

    always_comb begin
        state_d     = state_q;
        blen_d      = blen_q;
        issued_d    = issued_q;
        sent_d      = accept ? sent_q + BLEN_W'(1) : sent_q;
        rd_en_c     = 1'b0;
        clr_full_c  = 1'b0;
        clr_empty_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !rd_empty) begin
                    state_d    = BURST;
                    blen_d     = (burst_len == '0) ? BLEN_W'(1) : burst_len;
                    issued_d   = '0;
                    sent_d     = '0;
                    clr_full_c = irq_full;
                end
            end
            BURST: begin
                if (issued_q == blen_q) begin
                    state_d = DRAIN;
                end else if (!rd_empty && credit_ok) begin
                    rd_en_c  = 1'b1;
                    issued_d = issued_q + BLEN_W'(1);
                end
            end
            DRAIN: begin
                if (accept && last_beat) begin
                    state_d     = IDLE;
                    clr_empty_c = irq_empty;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign outst_d      = outst_q + CNT_W'(rd_en) - CNT_W'(valid_eff);
    assign flush_d      = (flush_q != '0) ? flush_q - FLUSH_W'(1) : flush_q;
    assign words_sent_d = words_sent_q + WORDS_W'(accept);

    always_ff @(posedge clk_periph) begin
        if (periph_rst) begin
            state_q      <= IDLE;
            blen_q       <= '0;
            issued_q     <= '0;
            sent_q       <= '0;
            outst_q      <= '0;
            flush_q      <= FLUSH_W'(RD_LAT);
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            blen_q       <= blen_d;
            issued_q     <= issued_d;
            sent_q       <= sent_d;
            outst_q      <= outst_d;
            flush_q      <= flush_d;
            words_sent_q <= words_sent_d;
        end
    end

    always_ff @(posedge clk_periph) begin
        if (!periph_rst && valid_eff) begin
            assert (outst_q != '0) else $error("rd_valid with no read outstanding");
        end
    end

    assign rd_en           = rd_en_c && !periph_rst;
    assign irq_clear_full  = clr_full_c && !periph_rst;
    assign irq_clear_empty = clr_empty_c && !periph_rst;
    assign m_valid         = !skid_empty;
    assign m_last          = m_valid && last_beat;
    assign busy            = (state_q != IDLE) || !skid_empty;
    assign words_sent      = words_sent_q;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a 1-cycle-latency FIFO read model.
module tb_fifo_drain_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned SKID_D = 4;
    localparam int unsigned BLEN_W = 8;

    logic              clk_periph = 1'b0;
    logic              periph_rst = 1'b1;
    logic              enable     = 1'b0;
    logic [BLEN_W-1:0] burst_len  = '0;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_empty   = 1'b1;
    logic              rd_full    = 1'b0;
    logic              irq_full   = 1'b0;
    logic              irq_empty  = 1'b0;
    logic              irq_clear_full, irq_clear_empty;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready    = 1'b0;
    logic              m_last;
    logic              busy;
    logic [31:0]       words_sent;

    logic              rd_valid_m = 1'b0;
    logic [DATA_W-1:0] rd_data_m  = '0;
    logic              inj_valid  = 1'b0;

    logic [DATA_W-1:0] fifo_q [$];
    logic [DATA_W:0]   beats  [$];
    logic [DATA_W-1:0] exp_q  [$];
    int                rd_cnt = 0, clr_full_cnt = 0, clr_empty_cnt = 0;
    int                n_vec = 0, n_err = 0;
    int                lat, snap;

    always #5 clk_periph = ~clk_periph;

    fifo_drain_ctrl #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .SKID_D (SKID_D),
        .BLEN_W (BLEN_W)
    ) dut (
        .clk_periph      (clk_periph),
        .periph_rst      (periph_rst),
        .enable          (enable),
        .burst_len       (burst_len),
        .rd_en           (rd_en),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_empty        (rd_empty),
        .rd_full         (rd_full),
        .irq_full        (irq_full),
        .irq_empty       (irq_empty),
        .irq_clear_full  (irq_clear_full),
        .irq_clear_empty (irq_clear_empty),
        .m_data          (m_data),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_last          (m_last),
        .busy            (busy),
        .words_sent      (words_sent)
    );

    assign rd_valid = rd_valid_m | inj_valid;
    assign rd_data  = inj_valid ? 32'hDEAD_BEEF : rd_data_m;

    // FIFO read-port model: registered empty flag, data one cycle after rd_en.
    always @(posedge clk_periph) begin
        logic [DATA_W-1:0] d;
        d = 32'hBAD0_BAD0;
        if (rd_en && fifo_q.size() > 0) d = fifo_q.pop_front();
        rd_valid_m <= rd_en;
        rd_data_m  <= d;
        rd_empty   <= (fifo_q.size() == 0);
    end

    always @(negedge clk_periph) begin
        #2;
        if (!periph_rst) begin
            if (m_valid && m_ready) beats.push_back({m_last, m_data});
            if (rd_en) rd_cnt++;
            if (irq_clear_full) clr_full_cnt++;
            if (irq_clear_empty) clr_empty_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_periph);
    endtask

    task automatic start_burst(input string tag);
        int n;
        n = 0;
        enable = 1'b1;
        while (!busy && n < 20) begin
            tick(1);
            n++;
        end
        enable = 1'b0;
        chk1({tag, "_start"}, busy, 1'b1);
    endtask

    task automatic wait_idle(input string tag, input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        chk1({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic check_beats(input string tag);
        logic [DATA_W:0]   b;
        logic [DATA_W-1:0] e;
        logic              last_e;
        chk({tag, "_count"}, beats.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e      = exp_q.pop_front();
            last_e = (exp_q.size() == 0);
            if (beats.size() > 0) begin
                b = beats.pop_front();
                chk({tag, "_data"}, b[DATA_W-1:0], e);
                chk1({tag, "_last"}, b[DATA_W], last_e);
            end
        end
        beats.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        tick(3);
        periph_rst = 1'b0;
        chk1("rst_rd_en", rd_en, 1'b0);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_m_last", m_last, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_words", words_sent, 32'h0);

        // Two 4-word bursts from a 10-word FIFO at full rate
        for (int i = 0; i < 10; i++) fifo_q.push_back(32'h100 + i);
        burst_len = 8'd4;
        m_ready   = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + i);
        start_burst("t1a");
        wait_idle("t1a", 100, lat);
        chk("t1a_latency", lat, 6);
        chk("t1a_words", words_sent, 4);
        check_beats("t1a");
        for (int i = 4; i < 8; i++) exp_q.push_back(32'h100 + i);
        start_burst("t1b");
        wait_idle("t1b", 100, lat);
        chk("t1b_latency", lat, 6);
        chk("t1b_words", words_sent, 8);
        check_beats("t1b");

        // 8-word burst against a stalled sink: reads stop at the credit limit
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'h200 + i);
        burst_len = 8'd8;
        m_ready   = 1'b0;
        tick(1);
        snap = rd_cnt;
        start_burst("t2");
        tick(20);
        chk("t2_reads_stalled", rd_cnt - snap, SKID_D);
        chk1("t2_rd_en_stalled", rd_en, 1'b0);
        chk1("t2_m_valid_held", m_valid, 1'b1);
        chk("t2_m_data_held", m_data, 32'h108);
        chk1("t2_m_last_held", m_last, 1'b0);
        m_ready = 1'b1;
        exp_q.push_back(32'h108);
        exp_q.push_back(32'h109);
        for (int i = 0; i < 6; i++) exp_q.push_back(32'h200 + i);
        wait_idle("t2", 100, lat);
        chk("t2_reads_total", rd_cnt - snap, 8);
        chk("t2_words", words_sent, 16);
        check_beats("t2");

        // FIFO runs dry mid-burst; burst resumes when more words arrive
        burst_len = 8'd5;
        start_burst("t3");
        tick(30);
        chk1("t3_busy_stall", busy, 1'b1);
        chk1("t3_rd_en_stall", rd_en, 1'b0);
        chk("t3_beats_stall", beats.size(), 2);
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'h300 + i);
        exp_q.push_back(32'h206);
        exp_q.push_back(32'h207);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h300 + i);
        wait_idle("t3", 100, lat);
        chk("t3_words", words_sent, 21);
        check_beats("t3");

        // IRQ acknowledge pulses
        chk("t4_no_clr_full_yet", clr_full_cnt, 0);
        chk("t4_no_clr_empty_yet", clr_empty_cnt, 0);
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'h400 + i);
        burst_len = 8'd3;
        irq_full  = 1'b1;
        irq_empty = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h400 + i);
        start_burst("t4");
        wait_idle("t4", 100, lat);
        tick(2);
        chk("t4_clr_full", clr_full_cnt, 1);
        chk("t4_clr_empty", clr_empty_cnt, 1);
        chk("t4_words", words_sent, 24);
        check_beats("t4");
        irq_full  = 1'b0;
        irq_empty = 1'b0;

        // Reset mid-burst with words in the skid buffer, then a late rd_valid
        for (int i = 0; i < 6; i++) fifo_q.push_back(32'h500 + i);
        burst_len = 8'd6;
        m_ready   = 1'b0;
        tick(1);
        start_burst("t5");
        tick(3);
        chk1("t5_m_valid_pre", m_valid, 1'b1);
        chk("t5_m_data_pre", m_data, 32'h500);
        periph_rst = 1'b1;
        tick(1);
        chk1("t5_rd_en", rd_en, 1'b0);
        chk1("t5_m_valid", m_valid, 1'b0);
        chk1("t5_m_last", m_last, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_clr_full", irq_clear_full, 1'b0);
        chk1("t5_clr_empty", irq_clear_empty, 1'b0);
        chk("t5_m_data", m_data, 32'h0);
        chk("t5_words", words_sent, 32'h0);
        periph_rst = 1'b0;
        inj_valid  = 1'b1;
        tick(1);
        inj_valid = 1'b0;
        tick(2);
        chk1("t5_late_valid_m_valid", m_valid, 1'b0);
        chk1("t5_late_valid_busy", busy, 1'b0);
        chk("t5_words_after", words_sent, 32'h0);
        beats.delete();

        // burst_len 0 acts as 1; words_sent wraps
        fifo_q.delete();
        fifo_q.push_back(32'h600);
        m_ready   = 1'b1;
        burst_len = 8'd0;
        tick(2);
        force dut.words_sent_q = 32'hFFFF_FFFF;
        #1;
        release dut.words_sent_q;
        tick(1);
        chk("t6_preload", words_sent, 32'hFFFF_FFFF);
        snap = rd_cnt;
        exp_q.push_back(32'h600);
        start_burst("t6");
        wait_idle("t6", 100, lat);
        chk("t6_reads", rd_cnt - snap, 1);
        chk("t6_words_wrap", words_sent, 32'h0);
        check_beats("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
